stream_chunker: RTL and testbench

Downstream stage of the byte-stream normalizer. It consumes a packed byte stream in which every beat is full except the final partial beat marked with tlast. The stream is cut into chunks of at most CHUNK_BEATS data beats. Each chunk is followed by one trailer beat carrying the chunk byte count, the chunk index and a final-chunk flag. The output feeds the DMA/host writer, which uses trailers to delimit compressed blocks.

---
 rtl/stream_chunker_pkg.sv | 26 ++
 rtl/stream_chunker.sv | 97 +++++++++
 tb/tb_stream_chunker.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_chunker_pkg.sv
// Shared definitions for the stream chunker: trailer field layout, FSM states
// and the byte-count helper used on tkeep.
package stream_chunker_pkg;

    localparam int TRAILER_BYTES_LSB = 0;
    localparam int TRAILER_IDX_LSB   = 32;
    localparam int TRAILER_FINAL_BIT = 64;

    // Widest tkeep the popcount helper handles (WIDTH up to 512 bits).
    localparam int MAX_BYTES = 64;

    typedef enum logic {
        ST_DATA,
        ST_TRAILER
    } chunk_state_t;

    function automatic logic [31:0] popcount(input logic [MAX_BYTES-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/stream_chunker.sv
// Cuts a packed byte stream into chunks of at most CHUNK_BEATS beats and
// follows every chunk with a trailer beat (byte count, chunk index, final flag).
module stream_chunker
    import stream_chunker_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int CHUNK_BEATS = 64
) (
    input  logic                 aclk,
    input  logic                 aresetn,

    input  logic [WIDTH-1:0]     i_data_tdata,
    input  logic [WIDTH/8-1:0]   i_data_tkeep,
    input  logic                 i_data_tlast,
    input  logic                 i_data_tvalid,
    output logic                 i_data_tready,

    output logic [WIDTH-1:0]     o_data_tdata,
    output logic [WIDTH/8-1:0]   o_data_tkeep,
    output logic                 o_data_tlast,
    output logic                 o_data_tvalid,
    input  logic                 o_data_tready,

    output chunk_state_t         dbg_state
);

    localparam int BYTES  = WIDTH / 8;
    localparam int BEAT_W = $clog2(CHUNK_BEATS + 1);

    chunk_state_t      state;
    logic [31:0]       byte_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic [31:0]       chunk_idx;
    logic              final_r;

    logic              out_free;
    logic              accept;
    logic              load_trailer;
    logic              chunk_end;
    logic [31:0]       beat_bytes;
    logic [WIDTH-1:0]  trailer_word;

    // Handshake: a beat moves on a channel only in a cycle where tvalid and
    // tready are both high; a held tvalid keeps its payload frozen until then.
    assign out_free      = !o_data_tvalid || o_data_tready;
    assign i_data_tready = (state == ST_DATA) && out_free;
    assign accept        = i_data_tvalid && i_data_tready;
    assign load_trailer  = (state == ST_TRAILER) && out_free;
    assign chunk_end     = i_data_tlast || ((32'(beat_cnt) + 32'd1) == 32'(CHUNK_BEATS));
    assign beat_bytes    = popcount(MAX_BYTES'(i_data_tkeep));
    assign dbg_state     = state;

    // byte_cnt already includes the closing beat when the trailer is built.
    always_comb begin
        trailer_word = '0;
        trailer_word[TRAILER_BYTES_LSB +: 32] = byte_cnt;
        trailer_word[TRAILER_IDX_LSB +: 32]   = chunk_idx;
        trailer_word[TRAILER_FINAL_BIT]       = final_r;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_DATA;
            byte_cnt      <= '0;
            beat_cnt      <= '0;
            chunk_idx     <= '0;
            final_r       <= 1'b0;
            o_data_tdata  <= '0;
            o_data_tkeep  <= '0;
            o_data_tlast  <= 1'b0;
            o_data_tvalid <= 1'b0;
        end else if (accept) begin
            o_data_tdata  <= i_data_tdata;
            o_data_tkeep  <= i_data_tkeep;
            o_data_tlast  <= 1'b0;
            o_data_tvalid <= 1'b1;
            byte_cnt      <= byte_cnt + beat_bytes;
            beat_cnt      <= beat_cnt + BEAT_W'(1);
            if (chunk_end) begin
                final_r <= i_data_tlast;
                state   <= ST_TRAILER;
            end
        end else if (load_trailer) begin
            o_data_tdata  <= trailer_word;
            o_data_tkeep  <= {BYTES{1'b1}};
            o_data_tlast  <= 1'b1;
            o_data_tvalid <= 1'b1;
            byte_cnt      <= '0;
            beat_cnt      <= '0;
            chunk_idx     <= final_r ? 32'd0 : chunk_idx + 32'd1;
            state         <= ST_DATA;
        end else if (o_data_tready) begin
            o_data_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_chunker.sv
// Randomized bench for stream_chunker: a packet-level model fills an expected
// queue, and a negedge monitor pops and compares every output handshake.
module tb_stream_chunker;
    import stream_chunker_pkg::*;

    localparam int WIDTH = 512;
    localparam int BYTES = WIDTH / 8;
    localparam int CB    = 4;
    localparam int OW    = 1 + BYTES + WIDTH;
    localparam logic [BYTES-1:0] KEEP_ALL = {BYTES{1'b1}};

    logic               aclk;
    logic               aresetn;
    logic [WIDTH-1:0]   i_tdata;
    logic [BYTES-1:0]   i_tkeep;
    logic               i_tlast;
    logic               i_tvalid;
    logic               i_tready;
    logic [WIDTH-1:0]   o_tdata;
    logic [BYTES-1:0]   o_tkeep;
    logic               o_tlast;
    logic               o_tvalid;
    logic               o_tready;
    chunk_state_t       dbg_state;

    stream_chunker #(.WIDTH(WIDTH), .CHUNK_BEATS(CB)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .i_data_tdata  (i_tdata),
        .i_data_tkeep  (i_tkeep),
        .i_data_tlast  (i_tlast),
        .i_data_tvalid (i_tvalid),
        .i_data_tready (i_tready),
        .o_data_tdata  (o_tdata),
        .o_data_tkeep  (o_tkeep),
        .o_data_tlast  (o_tlast),
        .o_data_tvalid (o_tvalid),
        .o_data_tready (o_tready),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;        // 0: always ready, 1: random 50%
    logic [OW-1:0] exp_q[$];
    int unsigned idx_m = 0;

    logic [WIDTH-1:0] pkt_data[64];
    logic [BYTES-1:0] pkt_keep[64];

    int cyc = 0;
    bit meas = 0;
    int out_n = 0, out_first = 0, out_last = 0, low_n = 0;

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            o_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Splits an n-beat packet into chunks of CB beats and appends the data
    // beats plus one trailer per chunk to the expected queue.
    task automatic model_packet(input int n);
        for (int s = 0; s < n; s += CB) begin
            int e = (s + CB < n) ? s + CB : n;
            int unsigned bytes = 0;
            logic [WIDTH-1:0] tw;
            bit fin;
            for (int b = s; b < e; b++) begin
                exp_q.push_back({1'b0, pkt_keep[b], pkt_data[b]});
                bytes += $countones(pkt_keep[b]);
            end
            fin = (e == n);
            tw = '0;
            tw[31:0]  = bytes;
            tw[63:32] = idx_m;
            tw[64]    = fin;
            exp_q.push_back({1'b1, KEEP_ALL, tw});
            idx_m = fin ? 0 : idx_m + 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] k, input logic l);
        bit done = 0;
        int waits = 0;
        @(negedge aclk);
        i_tdata = d; i_tkeep = k; i_tlast = l; i_tvalid = 1'b1;
        while (!done) begin
            #2;
            if (i_tready) done = 1;
            @(posedge aclk);
            if (!done) begin
                @(negedge aclk);
                waits++;
                if (waits > 1000) begin
                    checks++; errors++;
                    $display("FAIL drive_timeout: actual=stalled required=accepted");
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle_input();
        @(negedge aclk);
        i_tvalid = 1'b0; i_tlast = 1'b0;
    endtask

    task automatic send_packet(input int n, input logic [BYTES-1:0] last_keep);
        for (int b = 0; b < n; b++) begin
            pkt_data[b] = rand_word();
            pkt_keep[b] = (b == n - 1) ? last_keep : KEEP_ALL;
        end
        model_packet(n);
        for (int b = 0; b < n; b++) drive_beat(pkt_data[b], pkt_keep[b], b == n - 1);
        idle_input();
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge aclk);
            w++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    bit               prev_stall = 0;
    logic [OW-1:0]    prev_word;

    always @(negedge aclk) begin
        logic [OW-1:0] act;
        logic [OW-1:0] exp;
        cyc++;
        act = {o_tlast, o_tkeep, o_tdata};
        if (!aresetn) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!o_tvalid || act !== prev_word) begin
                    errors++;
                    $display("FAIL stall_stable: actual=%0b/0x%0h required=1/0x%0h",
                             o_tvalid, act[OW-1:WIDTH], prev_word[OW-1:WIDTH]);
                end
            end
            if (meas && !i_tready) low_n++;
            if (o_tvalid && o_tready) begin
                if (meas) begin
                    if (out_n == 0) out_first = cyc;
                    out_last = cyc;
                    out_n++;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: actual=0x%0h required=none", act[OW-1:WIDTH-128]);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL out_beat: actual=%0b/%0h/%0h required=%0b/%0h/%0h",
                                 act[OW-1], act[WIDTH +: BYTES], act[79:0],
                                 exp[OW-1], exp[WIDTH +: BYTES], exp[79:0]);
                    end
                end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_word  = act;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        aresetn = 1'b0;
        i_tdata = '0; i_tkeep = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("reset_tvalid", 64'(o_tvalid), 64'd0);
        check("reset_tlast", 64'(o_tlast), 64'd0);
        check("reset_tkeep", 64'(o_tkeep), 64'd0);
        check("reset_tdata_or", 64'(|o_tdata), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_DATA));
        aresetn = 1'b1;
        @(negedge aclk);
        check("idle_in_ready", 64'(i_tready), 64'd1);

        // Four full beats ending exactly on the chunk limit.
        send_packet(4, KEEP_ALL);
        wait_drain();

        // Ten beats, partial last beat: chunks of 4, 4, 2.
        send_packet(10, 64'hF);
        wait_drain();

        // Single one-byte beat; following packet restarts at index 0.
        send_packet(1, 64'h1);
        wait_drain();

        // Ten-beat case again under random output backpressure.
        ready_mode = 1;
        send_packet(10, 64'hF);
        wait_drain();
        ready_mode = 0;

        // Reset after two accepted beats: partial chunk dropped, no trailer.
        pkt_data[0] = rand_word(); pkt_data[1] = rand_word();
        exp_q.push_back({1'b0, KEEP_ALL, pkt_data[0]});
        exp_q.push_back({1'b0, KEEP_ALL, pkt_data[1]});
        drive_beat(pkt_data[0], KEEP_ALL, 1'b0);
        drive_beat(pkt_data[1], KEEP_ALL, 1'b0);
        @(negedge aclk);
        #1;
        aresetn = 1'b0;
        i_tvalid = 1'b0;
        @(negedge aclk);
        check("mid_reset_tvalid", 64'(o_tvalid), 64'd0);
        check("mid_reset_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        idx_m = 0;
        aresetn = 1'b1;
        send_packet(1, KEEP_ALL);
        wait_drain();

        // Eight continuous full beats with constant output ready.
        meas = 1; out_n = 0; low_n = 0;
        send_packet(8, KEEP_ALL);
        for (int w = 0; w < 200 && out_n < 10; w++) @(negedge aclk);
        meas = 0;
        check("burst_out_beats", 64'(out_n), 64'd10);
        check("burst_out_span", 64'(out_last - out_first), 64'd9);
        check("burst_in_stalls", 64'(low_n), 64'd2);
        wait_drain();

        // Random packets under random backpressure.
        ready_mode = 1;
        for (int p = 0; p < 8; p++) begin
            int n = $urandom_range(1, 12);
            int k = $urandom_range(1, BYTES);
            logic [BYTES-1:0] lk;
            lk = (k == BYTES) ? KEEP_ALL : ((64'd1 << k) - 64'd1);
            send_packet(n, lk);
        end
        wait_drain();
        ready_mode = 0;
        repeat (4) @(negedge aclk);
        check("final_state", 64'(dbg_state), 64'(ST_DATA));
        check("final_tvalid", 64'(o_tvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
